store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 36 +++
 rtl/sb_fifo.sv | 81 ++++++++
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared size encodings, byte-offset constants and lane helpers for the store buffer.
// Used by both the memory load-return path and the forwarding path.
package store_buffer_pkg;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  // Memory returns data right-aligned, so the load-return path extracts from offset 0.
  localparam logic [1:0] OFF_ALIGNED = 2'b00;

  function automatic logic is_word(input logic [1:0] sz);
    return (sz == SZ_WORD) || (sz == SZ_WORD_ALT);
  endfunction

  // Shift the addressed lane down to bit 0, then zero- or sign-extend it.
  function automatic logic [31:0] lane_extend(input logic [31:0] d, input logic [1:0] off,
                                               input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    s = d >> {off, 3'b000};
    case (sz)
      SZ_BYTE: lane_extend = {{24{s[7] & ~uns}}, s[7:0]};
      SZ_HALF: lane_extend = {{16{s[15] & ~uns}}, s[15:0]};
      default: lane_extend = s;
    endcase
  endfunction

  // Replicate narrow store data across all lanes so memory can pick any byte enable.
  function automatic logic [31:0] lane_replicate(input logic [31:0] d, input logic [1:0] sz);
    if (is_word(sz)) return d;
    else if (sz == SZ_HALF) return {2{d[15:0]}};
    else return {4{d[7:0]}};
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer storage: circular FIFO of {addr, wdata, size} with word-address match compare.
// With STORE_FWD_EN, also reports the youngest matching entry's data and whether it is a word.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [31:0]              push_addr,
  input  logic [31:0]              push_data,
  input  logic [1:0]               push_size,
  input  logic [29:0]              match_word,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              head_addr,
  output logic [31:0]              head_data,
  output logic [1:0]               head_size,
  output logic                     hit
`ifdef STORE_FWD_EN
  ,
  output logic [31:0]              fwd_data,
  output logic                     fwd_word
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [1:0]    size_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
      size_q[wr_ptr] <= push_size;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_size = size_q[rd_ptr];

  // Walk oldest to youngest so the last hit seen is the youngest match.
  always_comb begin
    logic [AW-1:0] idx;
    idx = '0;
    hit = 1'b0;
`ifdef STORE_FWD_EN
    fwd_data = '0;
    fwd_word = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (((AW+1)'(i) < count) && (addr_q[idx][31:2] == match_word)) begin
        hit = 1'b1;
`ifdef STORE_FWD_EN
        fwd_data = data_q[idx];
        fwd_word = is_word(size_q[idx]);
`endif
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: queues stores, drains them when the port is free, stalls hazard loads.
// Optional store-to-load forwarding of word entries is enabled by defining STORE_FWD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_req,
  input  logic        ld_req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  input  logic        drain,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        empty,
  output logic        MemWrite,
  output logic        MemRead,
  output logic        HalfOperation,
  output logic        ByteOperation,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   count;
  logic [31:0]   head_addr;
  logic [31:0]   head_data;
  logic [1:0]    head_size;
  logic          hit;
  logic          fwd_ok;
  logic          stall_i;
  logic          ld_acc;
  logic          push;
  logic          pop;
  logic          full;
  logic          busy;
`ifdef STORE_FWD_EN
  logic [31:0]   fwd_data;
  logic          fwd_word;
`endif

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .push_addr  (addr),
    .push_data  (wdata),
    .push_size  (size),
    .match_word (addr[31:2]),
    .count      (count),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .head_size  (head_size),
    .hit        (hit)
`ifdef STORE_FWD_EN
    ,
    .fwd_data   (fwd_data),
    .fwd_word   (fwd_word)
`endif
  );

`ifdef STORE_FWD_EN
  assign fwd_ok = hit && fwd_word;
`else
  assign fwd_ok = 1'b0;
`endif

  assign full    = (count == (AW+1)'(DEPTH));
  assign busy    = (count != '0);
  assign empty   = !busy;
  // A stalled request is replayed, so nothing of it may take effect this cycle.
  assign stall_i = (drain && busy) || (ld_req && hit && !fwd_ok) || (st_req && !ld_req && full);
  assign ld_acc  = ld_req && !stall_i;
  assign push    = st_req && !ld_req && !stall_i;
  assign pop     = !rst && !ld_acc && busy;
  assign stall   = stall_i && !rst;

  always_comb begin
    MemWrite      = 1'b0;
    MemRead       = 1'b0;
    HalfOperation = 1'b0;
    ByteOperation = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    ld_data       = '0;
    if (rst) begin
      MemWrite = 1'b0;
    end else if (ld_acc && !fwd_ok) begin
      MemRead       = 1'b1;
      mem_addr      = addr;
      HalfOperation = (size == SZ_HALF);
      ByteOperation = (size == SZ_BYTE);
      ld_data       = lane_extend(mem_rdata, OFF_ALIGNED, size, ld_unsigned);
`ifdef STORE_FWD_EN
    end else if (ld_acc) begin
      ld_data = lane_extend(fwd_data, addr[1:0], size, ld_unsigned);
`endif
    end else if (busy) begin
      MemWrite      = 1'b1;
      mem_addr      = head_addr;
      mem_wdata     = lane_replicate(head_data, head_size);
      HalfOperation = (head_size == SZ_HALF);
      ByteOperation = (head_size == SZ_BYTE);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue-based reference model with byte memories.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_req, ld_req, ld_unsigned, drain;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        stall, empty, MemWrite, MemRead, HalfOperation, ByteOperation;
  logic [31:0] ld_data, mem_addr, mem_wdata, mem_rdata;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_req(st_req), .ld_req(ld_req), .addr(addr), .wdata(wdata),
    .size(size), .ld_unsigned(ld_unsigned), .drain(drain), .stall(stall), .ld_data(ld_data),
    .empty(empty), .MemWrite(MemWrite), .MemRead(MemRead), .HalfOperation(HalfOperation),
    .ByteOperation(ByteOperation), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // bmem is the memory the DUT sees; mmem is the model's expected memory image.
  logic [7:0] bmem [1024];
  logic [7:0] mmem [1024];

  always_comb mem_rdata = {bmem[mem_addr[9:0] + 10'd3], bmem[mem_addr[9:0] + 10'd2],
                           bmem[mem_addr[9:0] + 10'd1], bmem[mem_addr[9:0]]};

  always @(posedge clk) begin
    if (MemWrite) begin
      if (ByteOperation)
        bmem[mem_addr[9:0]] <= 8'(mem_wdata >> (8 * mem_addr[1:0]));
      else if (HalfOperation) begin
        bmem[mem_addr[9:0]]         <= 8'(mem_wdata >> (8 * mem_addr[1:0]));
        bmem[mem_addr[9:0] + 10'd1] <= 8'(mem_wdata >> (8 * mem_addr[1:0] + 8));
      end else
        for (int k = 0; k < 4; k++) bmem[mem_addr[9:0] + 10'(k)] <= 8'(mem_wdata >> (8 * k));
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [31:0] v, input logic [1:0] sz, input logic uns);
    logic [31:0] r;
    r = v;
    if (sz == 2'd0) begin
      r = v % 256;
      if (!uns && r >= 128) r = r + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      r = v % 65536;
      if (!uns && r >= 32768) r = r + 32'hFFFF0000;
    end
    return r;
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a);
    logic [31:0] v;
    v = 0;
    for (int k = 3; k >= 0; k--) v = v * 256 + 32'(mmem[(a + k) % 1024]);
    return v;
  endfunction

  task automatic step(input logic s, input logic l, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic u, input logic dr, input logic r);
    int          n;
    logic        hz, fw, es, la, emw, emr, eh, eb;
    logic [31:0] fd, ema, emd, eld;
    @(posedge clk);
    #1;
    st_req = s; ld_req = l; addr = a; wdata = wd; size = sz; ld_unsigned = u; drain = dr; rst = r;
    @(negedge clk);
    if (r) begin
      check("rst_stall", stall, 0);
      check("rst_memwrite", MemWrite, 0);
      check("rst_memread", MemRead, 0);
      check("rst_half_byte", {HalfOperation, ByteOperation}, 0);
      check("rst_ld_data", ld_data, 0);
      check("rst_empty", empty, 1);
      q.delete();
      return;
    end
    n = q.size();
    hz = 0; fw = 0; fd = 0;
    foreach (q[i]) if (q[i].a[31:2] == a[31:2]) begin
      hz = 1;
      fd = q[i].d;
`ifdef STORE_FWD_EN
      fw = (q[i].sz >= 2);
`endif
    end
    es  = (dr && n > 0) || (l && hz && !fw) || (s && !l && n == DEPTH);
    la  = l && !es;
    emw = 0; emr = 0; eh = 0; eb = 0; ema = 0; emd = 0; eld = 0;
    if (la && !fw) begin
      emr = 1; ema = a; eh = (sz == 1); eb = (sz == 0);
      eld = ext(mrd(a), sz, u);
    end else if (la) begin
      eld = ext(fd >> (8 * a[1:0]), sz, u);
    end else if (n > 0) begin
      emw = 1; ema = q[0].a; eh = (q[0].sz == 1); eb = (q[0].sz == 0);
      if (q[0].sz == 0) emd = q[0].d[7:0] * 32'h01010101;
      else if (q[0].sz == 1) emd = q[0].d[15:0] * 32'h00010001;
      else emd = q[0].d;
    end
    check("stall", stall, es);
    check("empty", empty, n == 0);
    check("memwrite", MemWrite, emw);
    check("memread", MemRead, emr);
    check("mem_addr", mem_addr, ema);
    check("mem_wdata", mem_wdata, emd);
    check("half_byte", {HalfOperation, ByteOperation}, {eh, eb});
    if (la) check("ld_data", ld_data, eld);
    if (emw) begin
      if (q[0].sz == 0) mmem[q[0].a % 1024] = q[0].d[7:0];
      else if (q[0].sz == 1) begin
        mmem[q[0].a % 1024] = q[0].d[7:0];
        mmem[(q[0].a + 1) % 1024] = q[0].d[15:8];
      end else
        for (int k = 0; k < 4; k++) mmem[(q[0].a + k) % 1024] = 8'(q[0].d >> (8 * k));
      void'(q.pop_front());
    end
    if (s && !l && !es) q.push_back('{a: a, d: wd, sz: sz});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 2'd2, 0, 0, 0);
  endtask

  initial begin
    logic [1:0]  rsz;
    logic [31:0] ra;
    for (int k = 0; k < 1024; k++) begin
      bmem[k] = 8'($urandom);
      mmem[k] = bmem[k];
    end
    st_req = 0; ld_req = 0; addr = 0; wdata = 0; size = 0; ld_unsigned = 0; drain = 0; rst = 1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 32'h40, 32'h1, 0, 0, 1, 1);
    idle();

    // Single word store drains the following cycle.
    step(1, 0, 32'h10, 32'hDEADBEEF, 2'd2, 0, 0, 0);
    idle();
    check("t_store_wdata", mem_wdata, 32'hDEADBEEF);
    idle();
    check("t_store_empty", empty, 1);

    // Byte store then hazard load, then signed/unsigned byte loads.
    step(1, 0, 32'h21, 32'h80, 2'd0, 0, 0, 0);
    step(0, 1, 32'h21, 0, 2'd0, 0, 0, 0);
    step(0, 1, 32'h21, 0, 2'd0, 0, 0, 0);
    check("t_lb", ld_data, 32'hFFFFFF80);
    step(0, 1, 32'h21, 0, 2'd0, 1, 0, 0);
    check("t_lbu", ld_data, 32'h00000080);

    // Loads interleaved with stores, then a fence and a reset mid-drain.
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 32'h80 + 32'(4 * k), 32'hA0 + 32'(k), 2'd2, 0, 0, 0);
      step(0, 1, 32'h100, 0, 2'd2, 0, 0, 0);
    end
    step(1, 0, 32'h30, 32'h5555AAAA, 2'd2, 0, 0, 0);
    step(0, 0, 0, 0, 2'd2, 0, 1, 0);
    step(0, 0, 0, 0, 2'd2, 0, 1, 0);
    step(1, 0, 32'h34, 32'h77, 2'd3, 0, 0, 0);
    step(0, 0, 0, 0, 2'd2, 0, 1, 1);
    idle();

`ifdef STORE_FWD_EN
    step(1, 0, 32'h40, 32'h12345678, 2'd2, 0, 0, 0);
    step(0, 1, 32'h42, 0, 2'd1, 0, 0, 0);
    check("t_fwd_ld", ld_data, 32'h00001234);
    check("t_fwd_memread", MemRead, 0);
    idle();
`endif

    for (int c = 0; c < 3000; c++) begin
      rsz = 2'($urandom);
      ra  = 32'($urandom_range(0, 63));
      if (rsz == 2'd1) ra[0] = 1'b0;
      if (rsz[1]) ra[1:0] = 2'b00;
      step(($urandom % 3) == 0, ($urandom % 3) == 0, ra, $urandom, rsz, 1'($urandom),
           ($urandom % 10) == 0, ($urandom % 150) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
